// File: rtl/async_fifo_prog.sv
// Dual-clock FIFO with gray-coded pointer crossing, per-domain fill counts and programmable
// almost-full/almost-empty flags. Define AFIFO_ERR_FLAGS_EN to add sticky overflow/underflow.
module async_fifo_prog #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
`ifdef AFIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DepthCnt  = PtrW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AfullCnt  = PtrW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AemptyCnt = PtrW'(AEMPTY_THRESH);

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = int'(ADDR_WIDTH) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0] wr_bin_q, wr_bin_d, wr_gray_q;
  logic [ADDR_WIDTH:0] rd_bin_q, rd_bin_d, rd_gray_q;
  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] rd_sync_q;  // rd_gray_q as seen by wr_clk
  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] wr_sync_q;  // wr_gray_q as seen by rd_clk
  logic [WIDTH-1:0] rd_data_q;
  logic wr_accept, rd_accept;

  // Write domain
  assign wr_accept = wr_en & ~full;
  assign wr_bin_d  = wr_bin_q + {{ADDR_WIDTH{1'b0}}, wr_accept};

  always_ff @(posedge wr_clk) begin
    if (wr_accept) begin
      mem_q[wr_bin_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      rd_sync_q <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= bin2gray(wr_bin_d);
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rd_gray_q};
    end
  end

  always_comb begin
    wr_count    = wr_bin_q - gray2bin(rd_sync_q[SYNC_STAGES-1]);
    full        = (wr_count == DepthCnt);
    almost_full = (wr_count >= AfullCnt);
  end

  // Read domain
  assign rd_accept = rd_en & ~empty;
  assign rd_bin_d  = rd_bin_q + {{ADDR_WIDTH{1'b0}}, rd_accept};

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      wr_sync_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= bin2gray(rd_bin_d);
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_gray_q};
      if (rd_accept) begin
        rd_data_q <= mem_q[rd_bin_q[ADDR_WIDTH-1:0]];
      end
    end
  end

  always_comb begin
    rd_count     = gray2bin(wr_sync_q[SYNC_STAGES-1]) - rd_bin_q;
    empty        = (rd_count == '0);
    almost_empty = (rd_count <= AemptyCnt);
  end

  assign rd_data = rd_data_q;

`ifdef AFIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      overflow_q <= 1'b0;
    end else if (wr_en & full) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      underflow_q <= 1'b0;
    end else if (rd_en & empty) begin
      underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  // Dropped accesses are silent: no error state is kept.
`endif

endmodule
